// File: rtl/spi_xip_ctrl.sv
// Execute-in-place bridge to a Wishbone SPI master. Register port and XIP read
// port share one master bus; optional poll timeout via SPI_XIP_TIMEOUT_EN.
module spi_xip_ctrl #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [15:0] CLK_DIV    = 16'h0001,
    parameter logic [7:0]  SS_MASK    = 8'h01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reg_valid,
    input  logic [4:0]  reg_addr,
    input  logic        reg_write,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_strb,
    output logic        reg_ready,
    output logic [31:0] reg_rdata,
    output logic        reg_err,
    input  logic        xip_valid,
    input  logic [31:0] xip_addr,
    input  logic        xip_write,
    output logic        xip_ready,
    output logic [31:0] xip_rdata,
    output logic        xip_err,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [3:0] {
        IDLE, REG, X_TX1, X_DIV, X_SS, X_CTRL, X_POLL, X_RX, X_SSOFF, RESP
    } state_t;

    state_t      state;
    logic        rr_xip;
    logic        gnt_xip;
    logic        err_q;
    logic        resp_q;
    logic [31:0] data_q;
`ifdef SPI_XIP_TIMEOUT_EN
    logic [9:0]  poll_cnt;
`endif

    logic        grant_xip;
    logic        xip_bad;
    logic [32:0] win_hi;
    logic [4:0]  s_adr;
    logic [31:0] s_dat;
    logic        s_we;

    assign win_hi    = {1'b0, FLASH_BASE} + 33'h0_00FF_FFFF;
    assign xip_bad   = xip_write || ({1'b0, xip_addr} < {1'b0, FLASH_BASE}) ||
                       ({1'b0, xip_addr} > win_hi);
    assign grant_xip = xip_valid && (!reg_valid || rr_xip);

    // Access issued by each XIP step after its idle gap cycle; X_TX1 is issued from IDLE.
    always_comb begin
        s_adr = 5'h00;
        s_dat = 32'h0;
        s_we  = 1'b1;
        case (state)
            X_DIV:   begin s_adr = 5'h14; s_dat = {16'h0, CLK_DIV}; end
            X_SS:    begin s_adr = 5'h18; s_dat = {24'h0, SS_MASK}; end
            X_CTRL:  begin s_adr = 5'h10; s_dat = 32'h0000_0140; end
            X_POLL:  begin s_adr = 5'h10; s_we = 1'b0; end
            X_RX:    begin s_adr = 5'h00; s_we = 1'b0; end
            X_SSOFF: begin s_adr = 5'h18; s_dat = 32'h0; end
            default: ;
        endcase
    end

    function automatic state_t step_next(input state_t s);
        case (s)
            X_TX1:   return X_DIV;
            X_DIV:   return X_SS;
            X_SS:    return X_CTRL;
            X_CTRL:  return X_POLL;
            X_RX:    return X_SSOFF;
            default: return RESP;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_xip    <= 1'b0;
            gnt_xip   <= 1'b0;
            err_q     <= 1'b0;
            resp_q    <= 1'b0;
            data_q    <= 32'h0;
            wb_adr_o  <= 5'h0;
            wb_dat_o  <= 32'h0;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            reg_ready <= 1'b0;
            reg_rdata <= 32'h0;
            reg_err   <= 1'b0;
            xip_ready <= 1'b0;
            xip_rdata <= 32'h0;
            xip_err   <= 1'b0;
`ifdef SPI_XIP_TIMEOUT_EN
            poll_cnt  <= 10'h0;
`endif
        end else begin
            reg_ready <= 1'b0;
            reg_rdata <= 32'h0;
            reg_err   <= 1'b0;
            xip_ready <= 1'b0;
            xip_rdata <= 32'h0;
            xip_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (reg_valid || xip_valid) begin
                        gnt_xip <= grant_xip;
                        err_q   <= 1'b0;
                        data_q  <= 32'h0;
                        resp_q  <= 1'b0;
                        // Pointer moves only on contention so an uncontested grant keeps fairness.
                        if (reg_valid && xip_valid)
                            rr_xip <= !grant_xip;
                        if (!grant_xip) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_adr_o <= reg_addr;
                            wb_dat_o <= reg_wdata;
                            wb_sel_o <= reg_strb;
                            wb_we_o  <= reg_write;
                            state    <= REG;
                        end else if (xip_bad) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_adr_o <= 5'h04;
                            wb_dat_o <= {8'h03, xip_addr[23:0]};
                            wb_sel_o <= 4'hF;
                            wb_we_o  <= 1'b1;
                            state    <= X_TX1;
                        end
                    end
                end
                REG: begin
                    if (wb_ack_i || wb_err_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        data_q   <= wb_dat_i;
                        err_q    <= wb_err_i;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // First RESP cycle is the post-access gap; the second carries the pulse.
                    if (!resp_q) begin
                        resp_q <= 1'b1;
                        if (gnt_xip) begin
                            xip_ready <= 1'b1;
                            xip_rdata <= {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
                            xip_err   <= err_q;
                        end else begin
                            reg_ready <= 1'b1;
                            reg_rdata <= data_q;
                            reg_err   <= err_q;
                        end
                    end else begin
                        resp_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= s_adr;
                        wb_dat_o <= s_dat;
                        wb_sel_o <= 4'hF;
                        wb_we_o  <= s_we;
                    end else if (wb_err_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= (state == X_SSOFF) ? RESP : X_SSOFF;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (state == X_POLL) begin
                            if (!wb_dat_i[8]) begin
                                state <= X_RX;
                            end else begin
`ifdef SPI_XIP_TIMEOUT_EN
                                if (poll_cnt == 10'h3FF) begin
                                    err_q <= 1'b1;
                                    state <= X_SSOFF;
                                end else begin
                                    poll_cnt <= poll_cnt + 10'h1;
                                end
`endif
                            end
                        end else if (state == X_RX) begin
                            data_q <= wb_dat_i;
                            state  <= X_SSOFF;
                        end else begin
`ifdef SPI_XIP_TIMEOUT_EN
                            if (state == X_CTRL)
                                poll_cnt <= 10'h0;
`endif
                            state <= step_next(state);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Directed bench for spi_xip_ctrl: Wishbone slave model, expected access lists
// and latencies derived from the XIP sequence rules.
`timescale 1ns/1ps
module tb_spi_xip_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reg_valid = 1'b0;
    logic [4:0]  reg_addr = 5'h0;
    logic        reg_write = 1'b0;
    logic [31:0] reg_wdata = 32'h0;
    logic [3:0]  reg_strb = 4'h0;
    logic        reg_ready;
    logic [31:0] reg_rdata;
    logic        reg_err;
    logic        xip_valid = 1'b0;
    logic [31:0] xip_addr = 32'h0;
    logic        xip_write = 1'b0;
    logic        xip_ready;
    logic [31:0] xip_rdata;
    logic        xip_err;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    always #5 clock = ~clock;

    spi_xip_ctrl dut (
        .clock(clock), .reset(reset),
        .reg_valid(reg_valid), .reg_addr(reg_addr), .reg_write(reg_write),
        .reg_wdata(reg_wdata), .reg_strb(reg_strb), .reg_ready(reg_ready),
        .reg_rdata(reg_rdata), .reg_err(reg_err),
        .xip_valid(xip_valid), .xip_addr(xip_addr), .xip_write(xip_write),
        .xip_ready(xip_ready), .xip_rdata(xip_rdata), .xip_err(xip_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct packed {
        logic [4:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } acc_t;

    // Slave model state (owned by the posedge process) and configuration (owned by the stimulus).
    acc_t        log_q[$];
    int          acc_total = 0;
    int          polls = 0;
    int          wcnt = 0;
    logic [31:0] rx0 = 32'h0;
    int          polls_base = 0;
    int          busy_polls = 0;
    int          wait_st = 0;
    int          err_at = -1;
    bit          stuck = 1'b0;
    logic        sl_busy, hit;

    assign sl_busy  = stuck || ((polls - polls_base + 1) < busy_polls);
    assign hit      = wb_cyc_o && wb_stb_o && (wcnt >= wait_st);
    assign wb_err_i = hit && (acc_total == err_at);
    assign wb_ack_i = hit && (acc_total != err_at);
    assign wb_dat_i = (wb_adr_o == 5'h10) ? {23'd0, sl_busy, 8'h40} :
                      (wb_adr_o == 5'h00) ? rx0 : {24'hA5A500, 3'b000, wb_adr_o};

    always @(posedge clock) begin
        if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
            log_q.push_back({wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o});
            acc_total <= acc_total + 1;
            if (wb_ack_i && !wb_we_o && wb_adr_o == 5'h10)
                polls <= polls + 1;
            wcnt <= 0;
        end else if (wb_cyc_o) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int          errors = 0;
    int          checks = 0;
    int          reg_pulses = 0, xip_pulses = 0;
    bit          p_cyc = 0, p_term = 0, p_rr = 0, p_xr = 0;
    logic [9:0]  p_ctl = '0;
    logic [31:0] p_dat = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return ((v & 32'h0000_00FF) << 24) | ((v & 32'h0000_FF00) << 8) |
               ((v >> 8) & 32'h0000_FF00) | (v >> 24);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [4:0] a);
        if (a == 5'h10) return 32'h0000_0040;
        if (a == 5'h00) return rx0;
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    // One cycle: bus protocol and output idle-value checks, sampled at negedge.
    task automatic tick();
        @(negedge clock);
        if (reset) begin
            p_cyc  = 0;
            p_term = 0;
        end else begin
            if (p_term)
                chk("wb_gap", wb_cyc_o, 0);
            else if (p_cyc && wb_cyc_o) begin
                chk("wb_hold_ctl", {wb_adr_o, wb_we_o, wb_sel_o}, p_ctl);
                chk("wb_hold_dat", wb_dat_o, p_dat);
            end
            p_cyc  = wb_cyc_o;
            p_term = wb_cyc_o && (wb_ack_i || wb_err_i);
            p_ctl  = {wb_adr_o, wb_we_o, wb_sel_o};
            p_dat  = wb_dat_o;
        end
        chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
        if (!reg_ready) chk("reg_idle", {reg_err, reg_rdata}, 0);
        if (!xip_ready) chk("xip_idle", {xip_err, xip_rdata}, 0);
        if (p_rr) chk("reg_pulse1", reg_ready, 0);
        if (p_xr) chk("xip_pulse1", xip_ready, 0);
        if (reg_ready) reg_pulses++;
        if (xip_ready) xip_pulses++;
        p_rr = reg_ready;
        p_xr = xip_ready;
    endtask

    task automatic reg_txn(input string nm, input logic [4:0] a, input bit wr,
                           input logic [31:0] wd, input logic [3:0] st, input int ws, input bit inj);
        int base, rp, xp, lat;
        bit got;
        logic [31:0] rd;
        logic er;
        base = acc_total; rp = reg_pulses; xp = xip_pulses;
        wait_st = ws; busy_polls = 0; stuck = 0;
        err_at = inj ? acc_total : -1;
        reg_addr = a; reg_write = wr; reg_wdata = wd; reg_strb = st; reg_valid = 1;
        got = 0; lat = 0; rd = 0; er = 0;
        while (!got && lat < 200) begin
            tick(); lat++;
            if (reg_ready) begin got = 1; rd = reg_rdata; er = reg_err; end
        end
        reg_valid = 0;
        chk({nm, "_done"}, got, 1);
        chk({nm, "_lat"}, lat, 3 + ws);
        chk({nm, "_err"}, er, inj);
        if (!wr && !inj) chk({nm, "_rdata"}, rd, slave_rd(a));
        tick();
        err_at = -1; wait_st = 0;
        chk({nm, "_nacc"}, acc_total - base, 1);
        if (log_q.size() > base) chk({nm, "_acc"}, log_q[base], {a, wr, wd, st});
        chk({nm, "_rpulses"}, reg_pulses - rp, 1);
        chk({nm, "_xpulses"}, xip_pulses - xp, 0);
    endtask

    task automatic xip_txn(input string nm, input logic [31:0] a, input bit wr, input int np,
                           input int err_k, input bit stk, input logic [31:0] rx,
                           output logic [31:0] rd_o, output int lat_o, output int base_o);
        acc_t exp_q[$];
        bit bad, eerr, got;
        int base, rp, xp, lat, npl, elat;
        logic er;
        bad = wr || (a < BASE) || ({1'b0, a} > ({1'b0, BASE} + 33'h0_00FF_FFFF));
        if (!bad) begin
            exp_q.push_back({5'h04, 1'b1, {8'h03, a[23:0]}, 4'hF});
            exp_q.push_back({5'h14, 1'b1, 32'h0000_0001, 4'hF});
            exp_q.push_back({5'h18, 1'b1, 32'h0000_0001, 4'hF});
            exp_q.push_back({5'h10, 1'b1, 32'h0000_0140, 4'hF});
            npl = stk ? 1024 : np;
            for (int i = 0; i < npl; i++) exp_q.push_back({5'h10, 1'b0, 32'h0, 4'hF});
            if (!stk) exp_q.push_back({5'h00, 1'b0, 32'h0, 4'hF});
            exp_q.push_back({5'h18, 1'b1, 32'h0, 4'hF});
            if (err_k >= 0) begin
                while (exp_q.size() > err_k + 1) void'(exp_q.pop_back());
                exp_q.push_back({5'h18, 1'b1, 32'h0, 4'hF});
            end
        end
        eerr = bad || stk || (err_k >= 0);
        elat = bad ? 2 : 2 * exp_q.size() + 1;
        base = acc_total; rp = reg_pulses; xp = xip_pulses;
        rx0 = rx; stuck = stk; busy_polls = np; polls_base = polls; wait_st = 0;
        err_at = (err_k >= 0) ? acc_total + err_k : -1;
        xip_addr = a; xip_write = wr; xip_valid = 1;
        got = 0; lat = 0; rd_o = 0; er = 0;
        while (!got && lat < 5000) begin
            tick(); lat++;
            if (xip_ready) begin got = 1; rd_o = xip_rdata; er = xip_err; end
        end
        xip_valid = 0; xip_write = 0;
        tick();
        stuck = 0; err_at = -1;
        chk({nm, "_done"}, got, 1);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_err"}, er, eerr);
        if (!eerr) chk({nm, "_rdata"}, rd_o, swap32(rx));
        chk({nm, "_nacc"}, acc_total - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
            chk($sformatf("%s_acc%0d_adr_we", nm, i), {log_q[base+i].adr, log_q[base+i].we},
                {exp_q[i].adr, exp_q[i].we});
            if (exp_q[i].we)
                chk($sformatf("%s_acc%0d_dat_sel", nm, i), {log_q[base+i].dat, log_q[base+i].sel},
                    {exp_q[i].dat, exp_q[i].sel});
        end
        chk({nm, "_xpulses"}, xip_pulses - xp, 1);
        chk({nm, "_rpulses"}, reg_pulses - rp, 0);
        lat_o = lat; base_o = base;
    endtask

    task automatic arb_round(input string nm, input bit xip_first);
        int tr, tx, t, base;
        base = acc_total; rx0 = 32'h0BAD_F00D; stuck = 0; busy_polls = 1; polls_base = polls;
        err_at = -1; wait_st = 0;
        reg_addr = 5'h00; reg_write = 0; reg_wdata = 32'h0; reg_strb = 4'hF;
        xip_addr = BASE + 32'h100; xip_write = 0;
        reg_valid = 1; xip_valid = 1;
        tr = 0; tx = 0; t = 0;
        while ((tr == 0 || tx == 0) && t < 300) begin
            tick(); t++;
            if (reg_ready && tr == 0) begin
                tr = t; reg_valid = 0;
                chk({nm, "_reg_rdata"}, reg_rdata, 32'h0BAD_F00D);
            end
            if (xip_ready && tx == 0) begin
                tx = t; xip_valid = 0;
                chk({nm, "_xip_rdata"}, {xip_err, xip_rdata}, {1'b0, 32'h0DF0_AD0B});
            end
        end
        chk({nm, "_t_reg"}, tr, xip_first ? 19 : 3);
        chk({nm, "_t_xip"}, tx, xip_first ? 15 : 19);
        if (log_q.size() > base) chk({nm, "_first_adr"}, log_q[base].adr, xip_first ? 5'h04 : 5'h00);
        tick();
    endtask

    task automatic do_reset();
        #1 reset = 1;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    logic [31:0] rd;
    int          lat, base, t0, rp0, xp0;

    initial begin
        tick(); tick();
        chk("rst_ctl", {reg_ready, reg_err, xip_ready, xip_err, wb_we_o, wb_stb_o, wb_cyc_o,
                        wb_sel_o, wb_adr_o}, 0);
        chk("rst_data", {reg_rdata, xip_rdata}, 0);
        chk("rst_wbdat", wb_dat_o, 0);
        reset = 0;
        tick();

        xip_txn("xip_basic", 32'h3000_0010, 0, 3, -1, 0, 32'h1122_3344, rd, lat, base);
        if (log_q.size() > base) chk("pin_tx1", log_q[base].dat, 32'h0300_0010);
        chk("pin_rdata", rd, 32'h4433_2211);
        chk("pin_lat", lat, 19);

        reg_txn("reg_rd", 5'h10, 0, 32'h0, 4'hF, 0, 0);
        reg_txn("reg_wr_wait", 5'h14, 1, 32'hDEAD_BEEF, 4'h6, 2, 0);
        reg_txn("reg_rd_wait", 5'h0C, 0, 32'h0, 4'hF, 1, 0);
        reg_txn("reg_err", 5'h08, 1, 32'h1234_5678, 4'hF, 0, 1);

        xip_txn("xip_write", BASE, 1, 1, -1, 0, 32'h0, rd, lat, base);
        chk("pin_wr_lat", lat, 2);
        xip_txn("xip_below", 32'h2FFF_FFFF, 0, 1, -1, 0, 32'h0, rd, lat, base);
        xip_txn("xip_above", 32'h3100_0000, 0, 1, -1, 0, 32'h0, rd, lat, base);
        xip_txn("xip_top", 32'h30FF_FFFF, 0, 1, -1, 0, 32'hA1B2_C3D4, rd, lat, base);
        if (log_q.size() > base) chk("pin_top_tx1", log_q[base].dat, 32'h03FF_FFFF);
        chk("pin_top_rdata", rd, 32'hD4C3_B2A1);
        chk("pin_top_lat", lat, 15);
        xip_txn("xip_err_ss", BASE + 32'h20, 0, 1, 2, 0, 32'h5555_AAAA, rd, lat, base);
        chk("pin_err_ss_lat", lat, 9);
        xip_txn("xip_err_poll", BASE + 32'h24, 0, 2, 5, 0, 32'h5555_AAAA, rd, lat, base);

        do_reset();
        arb_round("arb1", 0);
        arb_round("arb2", 1);

        // Reset while the poll loop is mid-access.
        rx0 = 32'h0; stuck = 1; busy_polls = 0; polls_base = polls; err_at = -1;
        rp0 = reg_pulses; xp0 = xip_pulses;
        xip_addr = BASE + 32'h80; xip_write = 0; xip_valid = 1;
        t0 = 0;
        while (!((polls - polls_base) >= 2 && wb_cyc_o && !wb_we_o && wb_adr_o == 5'h10) && t0 < 200) begin
            tick(); t0++;
        end
        chk("rst_poll_reached", t0 < 200, 1);
        #1 reset = 1;
        #1 chk("rst_async_bus", {wb_cyc_o, wb_stb_o}, 0);
        chk("rst_async_ready", {reg_ready, xip_ready}, 0);
        xip_valid = 0; stuck = 0;
        tick(); tick();
        reset = 0;
        repeat (10) tick();
        chk("rst_no_pulse", {reg_pulses - rp0, xip_pulses - xp0}, 0);
        reg_txn("reg_after_rst", 5'h10, 0, 32'h0, 4'hF, 0, 0);

`ifdef SPI_XIP_TIMEOUT_EN
        xip_txn("xip_timeout", BASE + 32'h40, 0, 0, -1, 1, 32'h0, rd, lat, base);
        chk("pin_timeout_lat", lat, 2059);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
